// File: rtl/fwd_hazard_tracker.sv
// rtl/fwd_hazard_tracker.sv - in-flight producer tracker with forward selects and load-use stall
//
// Tracks the EX instruction (entry 0) and DEPTH older producers (entries 1..DEPTH) in a
// shift register. The block then derives operand forward selects for EX and a load-use
// stall for ID from that history. It does not use pipeline-register taps.
//
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-low reset, clears all tracked entries
//   hold_i         global freeze, all state held; overrides flush_i and stall_o
//   flush_i        kill the instruction leaving ID (bubble into EX)
//   id_valid_i     ID holds a real instruction
//   id_src_i       ID source regs, src s at [s*REG_ADDR_W +: REG_ADDR_W]
//   id_rd_i        ID destination reg
//   id_regwrite_i  ID instruction writes rd
//   id_memread_i   ID instruction is a load
//   fwd_sel_o      per EX source: 0 = register file, k = tracked stage k
//   stall_o        hold PC/IF-ID and insert a bubble into EX
//   err_o          an EX source matches a producer whose data is not yet forwardable

module fwd_hazard_tracker #(
  parameter  int REG_ADDR_W = 5,
  parameter  int NUM_SRC    = 2,
  parameter  int DEPTH      = 3,
  parameter  int LOAD_LAT   = 2,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          hold_i,
  input  logic                          flush_i,
  input  logic                          id_valid_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_i,
  input  logic [REG_ADDR_W-1:0]         id_rd_i,
  input  logic                          id_regwrite_i,
  input  logic                          id_memread_i,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel_o,
  output logic                          stall_o,
  output logic                          err_o
);

  // Entry 0 is the EX instruction; entries 1..DEPTH are older producers.
  logic [DEPTH:0]                  valid_q;
  logic [DEPTH:0]                  regwrite_q;
  logic [DEPTH:0]                  memread_q;
  logic [REG_ADDR_W-1:0]           rd_q [DEPTH+1];
  logic [NUM_SRC*REG_ADDR_W-1:0]   ex_src_q;

  logic                            ex_valid_d;

  // The ID instruction only enters EX when it is real, not flushed and not stalled.
  assign ex_valid_d = id_valid_i & ~flush_i & ~stall_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q    <= '0;
      regwrite_q <= '0;
      memread_q  <= '0;
      ex_src_q   <= '0;
      for (int k = 0; k <= DEPTH; k++) begin
        rd_q[k] <= '0;
      end
    end else if (!hold_i) begin
      for (int k = 1; k <= DEPTH; k++) begin
        valid_q[k]    <= valid_q[k-1];
        regwrite_q[k] <= regwrite_q[k-1];
        memread_q[k]  <= memread_q[k-1];
        rd_q[k]       <= rd_q[k-1];
      end
      valid_q[0]    <= ex_valid_d;
      regwrite_q[0] <= id_regwrite_i;
      memread_q[0]  <= id_memread_i;
      rd_q[0]       <= id_rd_i;
      ex_src_q      <= id_src_i;
    end
  end

  // Forward selects for the EX sources. The downward scan leaves the youngest match
  // in place. A load whose data is not yet available yields sel 0 and flags err_o.
  always_comb begin : fwd_logic
    logic                  found;
    logic                  ready;
    int                    youngest;
    logic [REG_ADDR_W-1:0] r;
    found     = 1'b0;
    ready     = 1'b0;
    youngest  = 0;
    r         = '0;
    fwd_sel_o = '0;
    err_o     = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      r        = ex_src_q[s*REG_ADDR_W +: REG_ADDR_W];
      found    = 1'b0;
      ready    = 1'b0;
      youngest = 0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (valid_q[k] && regwrite_q[k] && (rd_q[k] != '0) && (rd_q[k] == r)) begin
          found    = 1'b1;
          youngest = k;
          ready    = !memread_q[k] || (k >= LOAD_LAT);
        end
      end
      if (valid_q[0] && found) begin
        if (ready) begin
          fwd_sel_o[s*SEL_W +: SEL_W] = SEL_W'(youngest);
        end else begin
          err_o = 1'b1;
        end
      end
    end
  end

  // Load-use check for ID sources against entries 0..DEPTH-1. When the ID instruction
  // reaches EX, entry j will be at stage j+1. Only the youngest writer counts, so a
  // younger ALU writer shadows an older load of the same register.
  always_comb begin : stall_logic
    logic                  early;
    logic                  any;
    logic [REG_ADDR_W-1:0] r;
    early = 1'b0;
    any   = 1'b0;
    r     = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      r     = id_src_i[s*REG_ADDR_W +: REG_ADDR_W];
      early = 1'b0;
      for (int j = DEPTH - 1; j >= 0; j--) begin
        if (valid_q[j] && regwrite_q[j] && (rd_q[j] != '0) && (rd_q[j] == r)) begin
          early = memread_q[j] && ((j + 1) < LOAD_LAT);
        end
      end
      any = any | early;
    end
    stall_o = id_valid_i & ~flush_i & any;
  end

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// tb/tb_fwd_hazard_tracker.sv - directed self-checking bench for fwd_hazard_tracker

module tb_fwd_hazard_tracker;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        hold_i;
  logic        flush_i;
  logic        id_valid_i;
  logic [4:0]  id_rd_i;
  logic        id_regwrite_i;
  logic        id_memread_i;
  logic [4:0]  s0, s1, s2;
  logic [9:0]  src_ab;
  logic [14:0] src_c;

  logic [3:0]  sel_a, sel_b;
  logic [8:0]  sel_c;
  logic        stall_a, stall_b, stall_c;
  logic        err_a, err_b, err_c;

  int n_tests = 0;
  int n_fail  = 0;

  assign src_ab = {s1, s0};
  assign src_c  = {s2, s1, s0};

  always #5 clk_i = ~clk_i;

  // Default build.
  fwd_hazard_tracker u_dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_src_i(src_ab), .id_rd_i(id_rd_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .fwd_sel_o(sel_a), .stall_o(stall_a), .err_o(err_a)
  );

  // Longer load latency.
  fwd_hazard_tracker #(.LOAD_LAT(3)) u_dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_src_i(src_ab), .id_rd_i(id_rd_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .fwd_sel_o(sel_b), .stall_o(stall_b), .err_o(err_b)
  );

  // Three sources, four tracked stages.
  fwd_hazard_tracker #(.NUM_SRC(3), .DEPTH(4)) u_dut_c (
    .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_src_i(src_c), .id_rd_i(id_rd_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .fwd_sel_o(sel_c), .stall_o(stall_c), .err_o(err_c)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    id_valid_i    = v;
    id_rd_i       = rd;
    id_regwrite_i = rw;
    id_memread_i  = mr;
    s0 = a;
    s1 = b;
    s2 = c;
    #1;
  endtask

  task automatic id_none();
    id_set(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic drain();
    id_none();
    repeat (5) step();
  endtask

  initial begin
    rst_i   = 1'b0;
    hold_i  = 1'b0;
    flush_i = 1'b0;
    id_none();
    chk("reset_sel",   sel_a,   0);
    chk("reset_stall", stall_a, 0);
    chk("reset_err",   err_a,   0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;

    // ALU chain: add r3,r1,r2 ; sub r7,r3,r3 ; or r8,r3,r0
    id_set(1, 5'd3, 1, 0, 5'd1, 5'd2, 5'd0);
    chk("alu_stall_add", stall_a, 0);
    step();
    id_set(1, 5'd7, 1, 0, 5'd3, 5'd3, 5'd0);
    chk("alu_stall_sub", stall_a, 0);
    step();
    id_set(1, 5'd8, 1, 0, 5'd3, 5'd0, 5'd0);
    chk("alu_sub_src0",  sel_a[1:0], 1);
    chk("alu_sub_src1",  sel_a[3:2], 1);
    chk("alu_stall_or",  stall_a, 0);
    step();
    id_none();
    chk("alu_or_src0", sel_a[1:0], 2);
    chk("alu_or_src1", sel_a[3:2], 0);
    drain();

    // Load-use: lw r5,0(r1) ; add r6,r5,r2
    id_set(1, 5'd5, 1, 1, 5'd1, 5'd0, 5'd0);
    chk("lu_stall_lw", stall_a, 0);
    step();
    id_set(1, 5'd6, 1, 0, 5'd5, 5'd2, 5'd0);
    chk("lu_a_stall1", stall_a, 1);
    chk("lu_b_stall1", stall_b, 1);
    step();
    chk("lu_a_stall2",  stall_a, 0);
    chk("lu_a_bubble",  sel_a,   0);
    chk("lu_a_err_bub", err_a,   0);
    chk("lu_b_stall2",  stall_b, 1);
    step();
    chk("lu_a_src0", sel_a[1:0], 2);
    chk("lu_a_src1", sel_a[3:2], 0);
    chk("lu_a_err",  err_a, 0);
    chk("lu_b_stall3", stall_b, 0);
    step();
    chk("lu_b_src0", sel_b[1:0], 3);
    chk("lu_b_err",  err_b, 0);
    drain();

    // r4 written at stage 1 and stage 2: youngest wins.
    id_set(1, 5'd4, 1, 0, 5'd1, 5'd1, 5'd0);
    step();
    id_set(1, 5'd4, 1, 0, 5'd2, 5'd2, 5'd0);
    step();
    id_set(1, 5'd9, 1, 0, 5'd4, 5'd0, 5'd0);
    step();
    id_none();
    chk("prio_src0", sel_a[1:0], 1);
    drain();

    // Writer with rd=0 at stage 2, regwrite=0 writer of r11 at stage 1.
    id_set(1, 5'd0, 1, 0, 5'd1, 5'd2, 5'd0);
    step();
    id_set(1, 5'd11, 0, 0, 5'd1, 5'd2, 5'd0);
    step();
    id_set(1, 5'd12, 1, 0, 5'd11, 5'd0, 5'd0);
    step();
    id_none();
    chk("zero_sel", sel_a, 0);
    chk("zero_err", err_a, 0);
    drain();

    // Younger ALU writer of r5 ahead of an older lw r5.
    id_set(1, 5'd5, 1, 1, 5'd1, 5'd0, 5'd0);
    step();
    id_set(1, 5'd5, 1, 0, 5'd1, 5'd2, 5'd0);
    step();
    id_set(1, 5'd10, 1, 0, 5'd5, 5'd0, 5'd0);
    chk("yalu_stall", stall_a, 0);
    step();
    id_none();
    chk("yalu_src0", sel_a[1:0], 1);
    chk("yalu_err",  err_a, 0);

    // Hold: lw r5,0(r10) in EX with r10 producer at stage 1, load-use pair in ID.
    id_set(1, 5'd5, 1, 1, 5'd10, 5'd0, 5'd0);
    step();
    hold_i = 1'b1;
    id_set(1, 5'd6, 1, 0, 5'd5, 5'd2, 5'd0);
    chk("hold_sel0",   sel_a[1:0], 1);
    chk("hold_stall0", stall_a, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold_sel_c%0d", i),   sel_a[1:0], 1);
      chk($sformatf("hold_stall_c%0d", i), stall_a, 1);
    end
    hold_i = 1'b0;
    step();
    id_none();
    chk("hold_rel_bubble", sel_a, 0);
    chk("hold_rel_err",    err_a, 0);
    drain();

    // Flush of a load-use pair in ID.
    id_set(1, 5'd5, 1, 1, 5'd1, 5'd0, 5'd0);
    step();
    flush_i = 1'b1;
    id_set(1, 5'd6, 1, 0, 5'd5, 5'd2, 5'd0);
    chk("flush_stall", stall_a, 0);
    step();
    flush_i = 1'b0;
    id_none();
    chk("flush_err", err_a, 0);
    chk("flush_sel", sel_a, 0);
    drain();

    // Hold together with flush: flush ignored, state frozen.
    id_set(1, 5'd12, 1, 0, 5'd1, 5'd2, 5'd0);
    step();
    id_set(1, 5'd12, 1, 0, 5'd12, 5'd0, 5'd0);
    step();
    hold_i  = 1'b1;
    flush_i = 1'b1;
    id_set(1, 5'd14, 1, 0, 5'd12, 5'd0, 5'd0);
    chk("hf_sel_pre", sel_a[1:0], 1);
    step();
    chk("hf_sel_held", sel_a[1:0], 1);
    hold_i = 1'b0;
    step();
    flush_i = 1'b0;
    id_none();
    chk("hf_flush_after", sel_a, 0);
    drain();

    // Three-source, depth-4 build: writers r20, r21, r22, r24, then consumer (r24, r21, r20).
    id_set(1, 5'd20, 1, 0, 5'd0, 5'd0, 5'd0);
    step();
    id_set(1, 5'd21, 1, 0, 5'd0, 5'd0, 5'd0);
    step();
    id_set(1, 5'd22, 1, 0, 5'd0, 5'd0, 5'd0);
    step();
    id_set(1, 5'd24, 1, 0, 5'd0, 5'd0, 5'd0);
    step();
    id_set(1, 5'd25, 1, 0, 5'd24, 5'd21, 5'd20);
    step();
    id_none();
    chk("c_src0", sel_c[2:0], 1);
    chk("c_src1", sel_c[5:3], 3);
    chk("c_src2", sel_c[8:6], 4);
    chk("c_err",  err_c, 0);
    chk("a_src0_same_seq", sel_a[1:0], 1);
    chk("a_src1_same_seq", sel_a[3:2], 3);
    drain();

    // Reset asserted mid-stream with forwarding and a stall active.
    id_set(1, 5'd3, 1, 0, 5'd1, 5'd2, 5'd0);
    step();
    id_set(1, 5'd5, 1, 1, 5'd3, 5'd0, 5'd0);
    step();
    id_set(1, 5'd6, 1, 0, 5'd5, 5'd2, 5'd0);
    chk("mrst_pre_sel",   sel_a[1:0], 1);
    chk("mrst_pre_stall", stall_a, 1);
    #1 rst_i = 1'b0;
    #1;
    chk("mrst_sel",   sel_a,   0);
    chk("mrst_stall", stall_a, 0);
    chk("mrst_err",   err_a,   0);
    #1 rst_i = 1'b1;
    step();
    id_set(1, 5'd7, 1, 0, 5'd3, 5'd5, 5'd0);
    chk("mrst_post_stall", stall_a, 0);
    step();
    id_none();
    chk("mrst_post_sel", sel_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
